// File: rtl/controller.sv
// Multi-cycle fetch/decode/execute control FSM for a small accumulator-style CPU.
// All strobes are combinational from the current state, the opcode and the ALU flags.
// Only the control lives here; the datapath is outside this module.
module controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] opcode,
  input  logic       za,
  input  logic       zb,
  input  logic       eq,
  input  logic       gt,
  input  logic       lt,
  output logic       loadA,
  output logic       loadB,
  output logic       loadC,
  output logic       loadIR,
  output logic       loadPC,
  output logic       incPC,
  output logic       mode,
  output logic       we_DM,
  output logic       selA,
  output logic       selB
);

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StDecode  = 2'd1,
    StExecute = 2'd2,
    StHalt    = 2'd3
  } state_e;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpLda  = 4'b0010;
  localparam logic [3:0] OpLdb  = 4'b0011;
  localparam logic [3:0] OpLdai = 4'b0100;
  localparam logic [3:0] OpLdbi = 4'b0101;
  localparam logic [3:0] OpStc  = 4'b0110;
  localparam logic [3:0] OpCmp  = 4'b0111;
  localparam logic [3:0] OpJmp  = 4'b1000;
  localparam logic [3:0] OpJza  = 4'b1001;
  localparam logic [3:0] OpJzb  = 4'b1010;
  localparam logic [3:0] OpJeq  = 4'b1011;
  localparam logic [3:0] OpJgt  = 4'b1100;
  localparam logic [3:0] OpJlt  = 4'b1101;
  localparam logic [3:0] OpHalt = 4'b1111;

  state_e state_q, state_d;

  // State register: reset wins over enable; disabled cycles hold the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  // Next state and strobe decode; every strobe is low while in reset or disabled.
  always_comb begin
    state_d = state_q;
    loadA   = 1'b0;
    loadB   = 1'b0;
    loadC   = 1'b0;
    loadIR  = 1'b0;
    loadPC  = 1'b0;
    incPC   = 1'b0;
    mode    = 1'b0;
    we_DM   = 1'b0;
    selA    = 1'b0;
    selB    = 1'b0;

    unique case (state_q)
      StFetch:   state_d = StDecode;
      StDecode:  state_d = StExecute;
      StExecute: state_d = (opcode == OpHalt) ? StHalt : StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StFetch;
    endcase

    if (!rst && en) begin
      case (state_q)
        StFetch: begin
          loadIR = 1'b1;
          incPC  = 1'b1;
        end
        StExecute: begin
          case (opcode)
            OpAdd:  loadC = 1'b1;
            OpSub: begin
              mode  = 1'b1;
              loadC = 1'b1;
            end
            OpLda: begin
              selA  = 1'b1;
              loadA = 1'b1;
            end
            OpLdb: begin
              selB  = 1'b1;
              loadB = 1'b1;
            end
            OpLdai: loadA  = 1'b1;
            OpLdbi: loadB  = 1'b1;
            OpStc:  we_DM  = 1'b1;
            OpCmp:  mode   = 1'b1;
            OpJmp:  loadPC = 1'b1;
            OpJza:  loadPC = za;
            OpJzb:  loadPC = zb;
            OpJeq:  loadPC = eq;
            OpJgt:  loadPC = gt;
            OpJlt:  loadPC = lt;
            default: ;  // NOP and HALT drive nothing
          endcase
        end
        default: ;  // DECODE and HALT drive nothing
      endcase
    end
  end

endmodule

// File: tb/tb_controller.sv
// Directed testbench for controller: a cycle-level behavioural model checked on every
// falling edge, plus hand-computed literal expectations at key points of the sequence.
module tb_controller;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] opcode;
  logic       za, zb, eq, gt, lt;
  logic       loadA, loadB, loadC, loadIR, loadPC, incPC, mode, we_DM, selA, selB;

  controller dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .opcode(opcode),
    .za    (za),
    .zb    (zb),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt),
    .loadA (loadA),
    .loadB (loadB),
    .loadC (loadC),
    .loadIR(loadIR),
    .loadPC(loadPC),
    .incPC (incPC),
    .mode  (mode),
    .we_DM (we_DM),
    .selA  (selA),
    .selB  (selB)
  );

  always #5 clk = ~clk;

  // Output bundle order: loadA loadB loadC loadIR loadPC incPC mode we_DM selA selB
  localparam logic [9:0] ExpNone  = 10'b0000000000;
  localparam logic [9:0] ExpFetch = 10'b0001010000;
  localparam logic [9:0] ExpAdd   = 10'b0010000000;
  localparam logic [9:0] ExpSub   = 10'b0010001000;
  localparam logic [9:0] ExpLdai  = 10'b1000000000;
  localparam logic [9:0] ExpLda   = 10'b1000000010;
  localparam logic [9:0] ExpStc   = 10'b0000000100;
  localparam logic [9:0] ExpJump  = 10'b0000100000;

  int checks = 0;
  int errors = 0;

  logic [9:0] outs;
  assign outs = {loadA, loadB, loadC, loadIR, loadPC, incPC, mode, we_DM, selA, selB};

  // Model: position within the 3-step instruction (0 fetch, 1 decode, 2 execute) and halt flag.
  int   m_step   = 0;
  logic m_halted = 1'b0;
  logic m_valid  = 1'b0;

  function automatic logic [9:0] model_outs(input int step, input logic halted,
                                            input logic r, input logic e,
                                            input logic [3:0] op,
                                            input logic fza, input logic fzb,
                                            input logic feq, input logic fgt,
                                            input logic flt);
    logic [9:0] o;
    o = ExpNone;
    if (r || !e || halted) return o;
    if (step == 0) return ExpFetch;
    if (step == 1) return o;
    // execute step: field-by-field from the instruction table
    if (op == 4'd0 || op == 4'd1) o[7] = 1'b1;                 // loadC
    if (op == 4'd1 || op == 4'd7) o[3] = 1'b1;                 // mode subtract
    if (op == 4'd2 || op == 4'd4) o[9] = 1'b1;                 // loadA
    if (op == 4'd3 || op == 4'd5) o[8] = 1'b1;                 // loadB
    if (op == 4'd2) o[1] = 1'b1;                               // selA memory
    if (op == 4'd3) o[0] = 1'b1;                               // selB memory
    if (op == 4'd6) o[2] = 1'b1;                               // we_DM
    case (op)
      4'd8:  o[5] = 1'b1;
      4'd9:  o[5] = fza;
      4'd10: o[5] = fzb;
      4'd11: o[5] = feq;
      4'd12: o[5] = fgt;
      4'd13: o[5] = flt;
      default: ;
    endcase
    return o;
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model advance on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_step   <= 0;
      m_halted <= 1'b0;
      m_valid  <= 1'b1;
    end else if (en && !m_halted) begin
      if (m_step == 2 && opcode == 4'b1111) m_halted <= 1'b1;
      else m_step <= (m_step + 1) % 3;
    end
  end

  // Compare process: every falling edge once the model is anchored by reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model", outs, model_outs(m_step, m_halted, rst, en, opcode, za, zb, eq, gt, lt));
      checks++;
      if (loadPC && incPC) begin
        errors++;
        $display("FAIL pc_exclusive at %0t: loadPC=%b incPC=%b required not both", $time,
                 loadPC, incPC);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [9:0] exp);
    #1;
    check(name, outs, exp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; opcode = 4'd0;
    za = 1'b0; zb = 1'b0; eq = 1'b0; gt = 1'b0; lt = 1'b0;
    step(2);
    lit("reset_outs", ExpNone);

    // ALU ops
    rst = 1'b0;
    lit("first_fetch", ExpFetch);
    step(1); lit("first_decode", ExpNone);
    step(1); lit("exec_add", ExpAdd);
    step(1); opcode = 4'd1; lit("fetch_repeat", ExpFetch);
    step(2); lit("exec_sub", ExpSub);

    // Loads and store
    step(1); opcode = 4'd4; step(2); lit("exec_ldai", ExpLdai);
    step(1); opcode = 4'd2; step(2); lit("exec_lda", ExpLda);
    step(1); opcode = 4'd6; step(2); lit("exec_stc", ExpStc);

    // Conditional jump on eq
    step(1); opcode = 4'd11; eq = 1'b1; lit("jeq_fetch", ExpFetch);
    step(2); lit("jeq_taken", ExpJump);
    step(1); eq = 1'b0;
    step(1); eq = 1'b1; lit("decode_eq_ignored", ExpNone);
    #2 eq = 1'b0;
    step(1); lit("jeq_not_taken", ExpNone);

    // Other flag jumps
    step(1); opcode = 4'd12; gt = 1'b1; step(2); lit("jgt_taken", ExpJump);
    step(1); opcode = 4'd9; gt = 1'b0; step(2); lit("jza_not_taken", ExpNone);

    // Enable freeze mid-DECODE
    step(1); opcode = 4'd0;
    step(1); en = 1'b0; lit("freeze_outs", ExpNone);
    step(4); en = 1'b1; lit("resume_decode", ExpNone);
    step(1); lit("resume_exec", ExpAdd);

    // Halt
    step(1); opcode = 4'b1111;
    step(2); lit("exec_halt", ExpNone);
    step(1); lit("halted", ExpNone);
    opcode = 4'd8; za = 1'b1; zb = 1'b1; eq = 1'b1; gt = 1'b1; lt = 1'b1;
    step(5); lit("halted_stays", ExpNone);
    rst = 1'b1; lit("reset_during_halt", ExpNone);
    step(1); rst = 1'b0; lit("post_halt_fetch", ExpFetch);
    step(2); lit("post_halt_jmp", ExpJump);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
